// File: rtl/store_buffer_pkg.sv
// Shared types for the word-store buffer: entry layout, word-compare base
// and the per-cycle memory-port action.
package store_buffer_pkg;
  localparam int SB_ADDR_LSB = 2;
  localparam int SB_AW       = 32;
  localparam int SB_DW       = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {MA_IDLE, MA_READ, MA_DRAIN} mem_act_e;
endpackage

// File: rtl/store_buffer_if.sv
// Pipeline and DataMemory signals of the store buffer. The buffer takes the
// slave view; the pipeline/memory environment takes the master view.
interface store_buffer_if #(parameter int AW = 32, parameter int DW = 32);
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_lh;
  logic          ld_lhu;
  logic          stall;
  logic [DW-1:0] ld_data;
  logic          ld_done;
  logic          buf_empty;
  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic          lh;
  logic          lhu;
  logic [DW-1:0] data_out;

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, ld_lh, ld_lhu, data_out,
    output stall, ld_data, ld_done, buf_empty, MemRead, MemWrite, address, data_in, lh, lhu
  );

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, ld_lh, ld_lhu, data_out,
    input  stall, ld_data, ld_done, buf_empty, MemRead, MemWrite, address, data_in, lh, lhu
  );
endinterface

// File: rtl/store_buffer_fifo.sv
// sb_fifo: circular store queue with head/tail/count and a per-slot word-match
// vector used by the load-hit check.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1),
  localparam int MW    = SB_AW - SB_ADDR_LSB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  sb_entry_t        push_entry,
  input  logic             pop,
  input  logic [MW-1:0]    match_word,
  output sb_entry_t        head,
  output logic [CW-1:0]    count,
  output logic [DEPTH-1:0] match
);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  sb_entry_t     mem_q [DEPTH];
  sb_entry_t     mem_d [DEPTH];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    mem_d   = mem_q;
    if (push) mem_d[tail_q] = push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign head  = mem_q[head_q];
  assign count = count_q;

  // A slot is live when its distance from head is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [PW-1:0] off;
    assign off      = PW'(i) - head_q;
    assign match[i] = (CW'(off) < count_q) &&
                      (mem_q[i].addr[SB_AW-1:SB_ADDR_LSB] == match_word);
  end
endmodule

// File: rtl/store_buffer.sv
// Word-store buffer between MEM stage and DataMemory: stores queue up, drain
// in load-free cycles; a load hitting a queued store stalls until it drains.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic           Clk,
  input logic           Reset,
  store_buffer_if.slave sb
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int MW = SB_AW - SB_ADDR_LSB;

  logic [DEPTH-1:0] match;
  logic [CW-1:0]    count;
  sb_entry_t        head, push_entry;
  logic             push, pop, hit;
  logic [MW-1:0]    match_word;
  mem_act_e         act;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (Clk),
    .rst       (Reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .match_word(match_word),
    .head      (head),
    .count     (count),
    .match     (match)
  );

  // A hit implies count>0, so the hit case and the idle drain share MA_DRAIN.
  always_comb begin
    match_word = MW'(sb.ld_addr[AW-1:SB_ADDR_LSB]);
    hit        = sb.ld_valid & (|match);
    if (sb.ld_valid && !hit)  act = MA_READ;
    else if (count != '0)     act = MA_DRAIN;
    else                      act = MA_IDLE;
    pop        = (act == MA_DRAIN);
    push       = sb.st_valid & ~sb.ld_valid & ((count < CW'(DEPTH)) | pop);
    push_entry = '{addr: SB_AW'(sb.st_addr), data: SB_DW'(sb.st_data)};
  end

  // Outputs are forced to idle while Reset is high, regardless of inputs.
  always_comb begin
    sb.stall     = ~Reset & ((sb.st_valid & ~push) | hit);
    sb.buf_empty = (count == '0);
    sb.MemRead   = 1'b0;
    sb.MemWrite  = 1'b0;
    sb.ld_done   = 1'b0;
    sb.address   = '0;
    sb.data_in   = '0;
    sb.ld_data   = '0;
    sb.lh        = 1'b0;
    sb.lhu       = 1'b0;
    if (!Reset) begin
      unique case (act)
        MA_READ: begin
          sb.MemRead = 1'b1;
          sb.ld_done = 1'b1;
          sb.address = sb.ld_addr;
          sb.ld_data = sb.data_out;
          sb.lh      = sb.ld_lh;
          sb.lhu     = sb.ld_lhu;
        end
        MA_DRAIN: begin
          sb.MemWrite = 1'b1;
          sb.address  = AW'(head.addr);
          sb.data_in  = DW'(head.data);
        end
        default: ;
      endcase
    end
  end
endmodule
